// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - fetch/host arbiter with response routing for the instruction SRAM
// Fetch has priority, the host is protected from starvation, and the host may lock the port for loading.

module instr_mem_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_STARVE = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    f_req_i,
   input  logic [ADDR_WIDTH-1:0]   f_addr_i,
   output logic                    f_gnt_o,
   output logic                    f_rvalid_o,
   output logic [DATA_WIDTH-1:0]   f_rdata_o,

   input  logic                    h_req_i,
   input  logic                    h_we_i,
   input  logic [ADDR_WIDTH-1:0]   h_addr_i,
   input  logic [DATA_WIDTH-1:0]   h_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] h_wmask_i,
   input  logic                    h_lock_i,
   output logic                    h_gnt_o,
   output logic                    h_rvalid_o,
   output logic [DATA_WIDTH-1:0]   h_rdata_o,

   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_rvalid_i,

   output logic                    locked_o
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       pend_valid_q;
   logic       pend_owner_q;   // 1: host owns the outstanding read, 0: fetch
   logic       f_gnt, h_gnt;
   logic       rd_gnt;
   logic       h_wr_gnt;
   logic       rsp_fire;

   // Arbitration and lock state machine
   always_comb begin
      f_gnt   = 1'b0;
      h_gnt   = 1'b0;
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (h_req_i && (!f_req_i || (starve_cnt_q == STARVE_LIMIT))) begin
               h_gnt = 1'b1;
            end else if (f_req_i) begin
               f_gnt = 1'b1;
            end
            if (h_gnt && h_lock_i) begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            h_gnt = h_req_i;
            if (!h_lock_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!pend_valid_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counts fetch wins while the host waits; any host win or host idle resets it
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if ((state_q == DRAIN) && (state_d == IDLE)) begin
         starve_cnt_d = 4'd0;
      end else if (h_gnt || !h_req_i) begin
         starve_cnt_d = 4'd0;
      end else if (f_gnt && (starve_cnt_q != STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   assign h_wr_gnt = h_gnt && h_we_i;
   assign rd_gnt   = f_gnt || (h_gnt && !h_we_i);
   assign rsp_fire = mem_rvalid_i && pend_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         pend_valid_q <= 1'b0;
         pend_owner_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         pend_valid_q <= rd_gnt;
         if (rd_gnt) begin
            pend_owner_q <= h_gnt;
         end
      end
   end

   // Memory port mux; write fields stay zero unless the host is writing
   always_comb begin
      mem_req_o   = f_gnt || h_gnt;
      mem_we_o    = h_wr_gnt;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
      if (h_gnt) begin
         mem_addr_o = h_addr_i;
      end else if (f_gnt) begin
         mem_addr_o = f_addr_i;
      end
      if (h_wr_gnt) begin
         mem_wdata_o = h_wdata_i;
         mem_wmask_o = h_wmask_i[MASK_WIDTH-1:0];
      end
   end

   assign f_gnt_o    = f_gnt;
   assign h_gnt_o    = h_gnt;
   assign f_rvalid_o = rsp_fire && !pend_owner_q;
   assign h_rvalid_o = rsp_fire && pend_owner_q;
   assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : '0;
   assign h_rdata_o  = h_rvalid_o ? mem_rdata_i : '0;
   assign locked_o   = (state_q != IDLE);

endmodule
